// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier control path:
// FSM state encoding, Booth bit-pair codes and the default operand width.
package booth_pkg;

    // Default operand width; matches the 3-bit shift counter and its seen4 flag.
    localparam int BOOTH_WIDTH = 4;

    // {Q0, Q(-1)} pairs that require an arithmetic step before the shift.
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    // Controller states. Encoding 3'd7 is unused and recovers to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_e;

endpackage : booth_pkg

// File: rtl/booth_controller.sv
// Radix-2 Booth multiplier control FSM.
// Sequences LOAD -> (CHECK -> [ADD|SUB] -> SHIFT) x WIDTH -> DONE and drives
// the external shift counter through clrc/count_up, watching seen_last.
// All outputs are Moore-decoded from the registered state.
// Optional macro BOOTH_ACK_EN: when defined, DONE is held until ack=1;
// otherwise DONE lasts exactly one cycle and ack is ignored.
module booth_controller
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q0,
    input  logic q_1,
    input  logic seen_last,
    input  logic ack,
    output logic ld_m,
    output logic ld_q,
    output logic clr_a,
    output logic clr_q1,
    output logic ld_a,
    output logic sub,
    output logic sh,
    output logic clrc,
    output logic count_up,
    output logic busy,
    output logic done
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] pair;

    assign pair = {q0, q_1};

    // The iteration count is enforced by the external counter's seen_last
    // flag, so WIDTH is kept only to document the configuration; ack is
    // only consumed when the acknowledge handshake is built in.
    logic unused_cfg;
    assign unused_cfg = (WIDTH > 0) & ack;

    // State register with synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; any unused encoding falls back to IDLE.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:  state_d = start ? LOAD : IDLE;
            LOAD:  state_d = CHECK;
            CHECK: begin
                if (pair == PAIR_ADD) begin
                    state_d = ADD;
                end else if (pair == PAIR_SUB) begin
                    state_d = SUB;
                end else begin
                    state_d = SHIFT;
                end
            end
            ADD:   state_d = SHIFT;
            SUB:   state_d = SHIFT;
            // seen_last reflects the count before this shift's increment.
            SHIFT: state_d = seen_last ? DONE : CHECK;
`ifdef BOOTH_ACK_EN
            DONE:  state_d = ack ? IDLE : DONE;
`else
            DONE:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode; everything defaults low.
    always_comb begin
        ld_m     = 1'b0;
        ld_q     = 1'b0;
        clr_a    = 1'b0;
        clr_q1   = 1'b0;
        ld_a     = 1'b0;
        sub      = 1'b0;
        sh       = 1'b0;
        clrc     = 1'b0;
        count_up = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            LOAD: begin
                ld_m   = 1'b1;
                ld_q   = 1'b1;
                clr_a  = 1'b1;
                clr_q1 = 1'b1;
                clrc   = 1'b1;
                busy   = 1'b1;
            end
            CHECK: begin
                busy = 1'b1;
            end
            ADD: begin
                ld_a = 1'b1;
                busy = 1'b1;
            end
            SUB: begin
                ld_a = 1'b1;
                sub  = 1'b1;
                busy = 1'b1;
            end
            SHIFT: begin
                sh       = 1'b1;
                count_up = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule : booth_controller
